display_scan_ctrl: RTL and testbench

Display multiplexer for the visitor counter. It latches a 4-digit BCD count, time-multiplexes it across a common-segment 7-segment display, and drives the 2x4 digit decoder through `s1`, `s0` and `en`. It sits directly upstream of decoder24: its `s1`, `s0` and `en` wire straight into the decoder's select and enable inputs, and `seg` drives the shared segment bus.

---
 rtl/display_pkg.sv | 26 ++
 rtl/bcd_to_seg7.sv | 30 +++
 rtl/display_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the visitor-counter display path:
// scan FSM states and active-high 7-segment patterns (bit 0 = a .. bit 6 = g).
package display_pkg;

    localparam int NDIG = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to 7-segment decoder; codes above 9 render a dash,
// and the blank flag overrides everything.
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nib)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scanner feeding a 2x4 digit decoder.
// Outputs are registered from next-state values so they always match the FSM.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        load,
    input  logic        disp_on,
    output logic        s1,
    output logic        s0,
    output logic        en,
    output logic [6:0]  seg
);

    localparam int            PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

    state_t              state, state_nxt;
    logic [PW-1:0]       pcnt, pcnt_nxt;
    logic [1:0]          dig, dig_nxt;
    logic [15:0]         stage, disp, disp_nxt;
    logic                pend, pend_nxt;
    logic                slot_end, wrap, zrun;
    logic [NDIG-1:0]     blank;
    logic [NDIG-1:0][6:0] seg_dig;

    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        dig_nxt   = dig;
        slot_end  = 1'b0;
        case (state)
            IDLE: begin
                pcnt_nxt = '0;
                dig_nxt  = '0;
                if (disp_on) state_nxt = GUARD;
            end
            GUARD: state_nxt = SHOW;
            SHOW: begin
                if (pcnt == PMAX) begin
                    pcnt_nxt  = '0;
                    dig_nxt   = dig + 2'd1;
                    state_nxt = GUARD;
                    slot_end  = 1'b1;
                end else begin
                    pcnt_nxt = pcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!disp_on) begin
            state_nxt = IDLE;
            pcnt_nxt  = '0;
            dig_nxt   = '0;
        end
    end

    assign wrap = slot_end && (dig == 2'd3) && disp_on;

    // New data only reaches disp while dark (IDLE) or at frame wrap, so a
    // frame never mixes digits from two different counts.
    always_comb begin
        disp_nxt = disp;
        pend_nxt = pend;
        if ((state == IDLE || wrap) && pend) begin
            disp_nxt = stage;
            pend_nxt = 1'b0;
        end
        if (load) begin
            if (wrap) begin
                disp_nxt = bcd_in;
                pend_nxt = 1'b0;
            end else begin
                pend_nxt = 1'b1;
            end
        end
    end

    // Digit k blanks when it and every higher nibble are zero; digit 0 never.
    always_comb begin
        blank = '0;
        zrun  = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            zrun     = zrun && (disp_nxt[4*k +: 4] == 4'd0);
            blank[k] = zrun && BLANK_LZ;
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_dec
        bcd_to_seg7 u_dec (
            .nib   (disp_nxt[4*g +: 4]),
            .blank (blank[g]),
            .seg   (seg_dig[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pcnt  <= '0;
            dig   <= '0;
            stage <= '0;
            disp  <= '0;
            pend  <= 1'b0;
            s1    <= 1'b0;
            s0    <= 1'b0;
            en    <= 1'b0;
            seg   <= SEG_BLANK;
        end else begin
            state <= state_nxt;
            pcnt  <= pcnt_nxt;
            dig   <= dig_nxt;
            disp  <= disp_nxt;
            pend  <= pend_nxt;
            if (load) stage <= bcd_in;
            {s1, s0} <= dig_nxt;
            en    <= (state_nxt == SHOW);
            seg   <= (state_nxt == IDLE) ? SEG_BLANK : seg_dig[dig_nxt];
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl at SCAN_DIV=4; one instance with
// leading-zero blanking and one without, sharing all inputs.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst, load, disp_on;
    logic [15:0] bcd_in;
    logic        s1a, s0a, ena, s1b, s0b, enb;
    logic [6:0]  sega, segb;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .disp_on(disp_on),
        .s1(s1a), .s0(s0a), .en(ena), .seg(sega)
    );

    display_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .disp_on(disp_on),
        .s1(s1b), .s0(s0b), .en(enb), .seg(segb)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full slot: a GUARD cycle (en low) then four SHOW cycles (en high).
    // Optional one-cycle load pulse sampled on the edge that enters GUARD.
    task automatic slot(input logic [1:0] d, input logic [6:0] ea, input logic [6:0] eb,
                        input bit chkb, input bit ld, input logic [15:0] ldv);
        if (ld) begin
            load   = 1'b1;
            bcd_in = ldv;
        end
        tick();
        load = 1'b0;
        chk($sformatf("guard_en d%0d", d),  16'(ena), 16'd0);
        chk($sformatf("guard_sel d%0d", d), 16'({s1a, s0a}), 16'(d));
        chk($sformatf("guard_seg d%0d", d), 16'(sega), 16'(ea));
        if (chkb) chk($sformatf("guard_seg_nolz d%0d", d), 16'(segb), 16'(eb));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("show_en d%0d", d),  16'(ena), 16'd1);
            chk($sformatf("show_sel d%0d", d), 16'({s1a, s0a}), 16'(d));
            chk($sformatf("show_seg d%0d", d), 16'(sega), 16'(ea));
        end
    endtask

    initial begin
        rst = 1'b1; disp_on = 1'b1; load = 1'b0; bcd_in = 16'h0;

        // reset held with display enabled
        tick(); tick();
        chk("rst_en",  16'(ena), 16'd0);
        chk("rst_sel", 16'({s1a, s0a}), 16'd0);
        chk("rst_seg", 16'(sega), 16'd0);
        rst = 1'b0;
        slot(2'd0, 7'h3F, 7'h3F, 1'b1, 1'b0, 16'h0);
        slot(2'd1, 7'h00, 7'h3F, 1'b1, 1'b0, 16'h0);
        disp_on = 1'b0;
        tick();
        chk("off_en",  16'(ena), 16'd0);
        chk("off_sel", 16'({s1a, s0a}), 16'd0);

        // load 0x1234 while idle: disp two cycles after the strobe
        load = 1'b1; bcd_in = 16'h1234;
        tick();
        load = 1'b0;
        chk("idle_disp_early", dut_a.disp, 16'h0000);
        tick();
        chk("idle_disp_late", dut_a.disp, 16'h1234);
        disp_on = 1'b1;
        slot(2'd0, 7'h66, 7'h66, 1'b1, 1'b0, 16'h0);
        slot(2'd1, 7'h4F, 7'h4F, 1'b1, 1'b0, 16'h0);
        slot(2'd2, 7'h5B, 7'h5B, 1'b1, 1'b0, 16'h0);
        slot(2'd3, 7'h06, 7'h06, 1'b1, 1'b0, 16'h0);
        slot(2'd0, 7'h66, 7'h66, 1'b1, 1'b0, 16'h0);

        // 0x0042: leading-zero blanking on A, zeros shown on B
        disp_on = 1'b0; load = 1'b1; bcd_in = 16'h0042;
        tick();
        load = 1'b0;
        chk("drop_en", 16'(ena), 16'd0);
        tick();
        disp_on = 1'b1;
        slot(2'd0, 7'h5B, 7'h5B, 1'b1, 1'b0, 16'h0);
        slot(2'd1, 7'h66, 7'h66, 1'b1, 1'b0, 16'h0);
        slot(2'd2, 7'h00, 7'h3F, 1'b1, 1'b0, 16'h0);
        slot(2'd3, 7'h00, 7'h3F, 1'b1, 1'b0, 16'h0);

        // 0x1111 running; two mid-frame loads, only the last lands at wrap
        disp_on = 1'b0; load = 1'b1; bcd_in = 16'h1111;
        tick();
        load = 1'b0;
        tick();
        disp_on = 1'b1;
        slot(2'd0, 7'h06, 7'h06, 1'b1, 1'b0, 16'h0);
        slot(2'd1, 7'h06, 7'h06, 1'b1, 1'b1, 16'h2222);
        slot(2'd2, 7'h06, 7'h06, 1'b1, 1'b1, 16'h3333);
        chk("pend_mid_frame", 16'(dut_a.pend), 16'd1);
        slot(2'd3, 7'h06, 7'h06, 1'b1, 1'b0, 16'h0);
        slot(2'd0, 7'h4F, 7'h4F, 1'b1, 1'b0, 16'h0);
        slot(2'd1, 7'h4F, 7'h4F, 1'b1, 1'b0, 16'h0);
        slot(2'd2, 7'h4F, 7'h4F, 1'b1, 1'b0, 16'h0);
        slot(2'd3, 7'h4F, 7'h4F, 1'b1, 1'b0, 16'h0);

        // load coincident with frame wrap goes straight to disp
        slot(2'd0, 7'h6F, 7'h6F, 1'b1, 1'b1, 16'h0A99);
        chk("wrap_load_pend", 16'(dut_a.pend), 16'd0);
        chk("wrap_load_disp", dut_a.disp, 16'h0A99);
        slot(2'd1, 7'h6F, 7'h6F, 1'b1, 1'b0, 16'h0);
        slot(2'd2, 7'h40, 7'h40, 1'b1, 1'b0, 16'h0);
        slot(2'd3, 7'h00, 7'h3F, 1'b1, 1'b0, 16'h0);

        // reset at dig 2 with data pending discards it
        slot(2'd0, 7'h6F, 7'h6F, 1'b1, 1'b0, 16'h0);
        slot(2'd1, 7'h6F, 7'h6F, 1'b1, 1'b1, 16'h5555);
        chk("pend_before_rst", 16'(dut_a.pend), 16'd1);
        tick();
        chk("d2_guard_sel", 16'({s1a, s0a}), 16'd2);
        rst = 1'b1;
        tick();
        chk("midrst_en",   16'(ena), 16'd0);
        chk("midrst_sel",  16'({s1a, s0a}), 16'd0);
        chk("midrst_seg",  16'(sega), 16'd0);
        chk("midrst_disp", dut_a.disp, 16'h0000);
        chk("midrst_pend", 16'(dut_a.pend), 16'd0);
        rst = 1'b0;
        slot(2'd0, 7'h3F, 7'h3F, 1'b1, 1'b0, 16'h0);

        // disp_on drop at dig 2, restart from dig 0
        slot(2'd1, 7'h00, 7'h3F, 1'b1, 1'b0, 16'h0);
        tick();
        chk("d2b_guard_en",  16'(ena), 16'd0);
        chk("d2b_guard_sel", 16'({s1a, s0a}), 16'd2);
        tick();
        chk("d2b_show_en", 16'(ena), 16'd1);
        disp_on = 1'b0;
        tick();
        chk("drop_d2_en",  16'(ena), 16'd0);
        chk("drop_d2_sel", 16'({s1a, s0a}), 16'd0);
        disp_on = 1'b1;
        slot(2'd0, 7'h3F, 7'h3F, 1'b1, 1'b0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
